// File: rtl/pl_mem_ctrl.sv
// pl_mem_ctrl
// -----------
// Data-memory access controller for the MEM stage of a five-stage pipeline.
// A load or store in MEM is turned into a registered request to a memory that
// completes in a variable number of cycles (dmem_ready). While the access is
// outstanding the earlier pipeline stages are frozen through 'stall'. An
// access that never completes is aborted after TIMEOUT wait cycles. A
// misaligned access is rejected without touching memory. Both faults set the
// sticky 'err' flag and block the register write of the faulting instruction.
//
// Parameters
//   TIMEOUT     maximum number of WAIT cycles before an access is aborted (2..31)
//
// Ports
//   clk         single clock, rising edge
//   clrn        asynchronous active-low reset
//   mwreg       register-write flag of the instruction in MEM
//   mm2reg      MEM instruction is a load
//   mwmem       MEM instruction is a store (wins if mm2reg is also set)
//   mal         memory address (ALU result)
//   mb          store data
//   dmem_rdata  memory read data
//   dmem_ready  memory completion strobe (only looked at while waiting)
//   dmem_req    memory request (registered)
//   dmem_we     memory write enable (registered)
//   dmem_addr   memory address (registered)
//   dmem_wdata  memory write data (registered)
//   stall       freezes PC, IF/ID, ID/EX and EX/MEM
//   wreg_o      gated write flag for the MEM/WB register
//   mm          load data for the MEM/WB register
//   err         sticky fault flag (timeout or misalignment)

module pl_mem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] mal,
    input  logic [31:0] mb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        stall,
    output logic        wreg_o,
    output logic [31:0] mm,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);
    localparam logic [4:0] CNT_MAX  = 5'd31;

    state_t      state_q,      state_d;
    logic        dmem_req_q,   dmem_req_d;
    logic        dmem_we_q,    dmem_we_d;
    logic [31:0] dmem_addr_q,  dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [31:0] buf_q,        buf_d;
    logic [4:0]  cnt_q,        cnt_d;
    logic        suppress_q,   suppress_d;
    logic        err_q,        err_d;

    logic access;
    logic is_load;
    logic aligned;

    assign access  = mm2reg | mwmem;
    assign is_load = mm2reg & ~mwmem;
    assign aligned = (mal[1:0] == 2'b00);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= ST_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
            buf_q        <= 32'd0;
            cnt_q        <= 5'd0;
            suppress_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            suppress_q   <= suppress_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        suppress_d   = suppress_q;
        err_d        = err_q;
        stall        = 1'b0;
        wreg_o       = mwreg;
        mm           = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    stall  = 1'b1;
                    wreg_o = 1'b0;
                    if (aligned) begin
                        state_d      = ST_WAIT;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = mwmem;
                        dmem_addr_d  = mal;
                        dmem_wdata_d = mb;
                        cnt_d        = 5'd0;
                    end else begin
                        // Rejected without a request; the buffer is cleared
                        // so a faulted load never forwards stale data.
                        state_d    = ST_DONE;
                        err_d      = 1'b1;
                        suppress_d = 1'b1;
                        buf_d      = 32'd0;
                    end
                end
            end

            ST_WAIT: begin
                stall  = 1'b1;
                wreg_o = 1'b0;
                if (dmem_ready) begin
                    if (is_load) begin
                        buf_d = dmem_rdata;
                    end
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        dmem_req_d = 1'b0;
                        dmem_we_d  = 1'b0;
                        err_d      = 1'b1;
                        suppress_d = 1'b1;
                        buf_d      = 32'd0;
                        state_d    = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // The instruction is still held in MEM here; it leaves the
                // stage at the end of this cycle.
                wreg_o     = mwreg & ~suppress_q;
                mm         = is_load ? buf_q : 32'd0;
                state_d    = ST_IDLE;
                suppress_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign err        = err_q;

endmodule
